// File: rtl/pcie_ingress_feeder.sv
`default_nettype none
// ============================================================================
// Module   : pcie_ingress_feeder
// Purpose  : Upstream stage of PCIE_trans. Accepts 6-bit words from a
//            valid/ready producer, buffers them in a small skid FIFO and
//            drives push/data_in_principal into the main FIFO. Honours the
//            Pausa_MF backpressure and the logic-master status, and holds
//            all traffic until the logic master leaves init.
// Ports    : clk, reset_L (async, active-low)
//            init, active_out, idle_out, error_out : logic-master status
//            in_valid, in_data, in_ready           : producer handshake
//            Pausa_MF                              : main-FIFO almost-full
//            push, data_in_principal               : registered main-FIFO write
//            state_o                               : 0 WAIT 1 FWD 2 PAUSE 3 ERR
//            push_count (wraps), drop_count (saturates)
// Revision : 1.0 - initial release
// ============================================================================
module pcie_ingress_feeder #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic             init,
  input  logic             in_valid,
  input  logic [5:0]       in_data,
  output logic             in_ready,
  input  logic             Pausa_MF,
  input  logic             active_out,
  input  logic             idle_out,
  input  logic             error_out,
  output logic             push,
  output logic [5:0]       data_in_principal,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] push_count,
  output logic [CNT_W-1:0] drop_count
);

  typedef enum logic [1:0] {
    S_WAIT  = 2'd0,
    S_FWD   = 2'd1,
    S_PAUSE = 2'd2,
    S_ERR   = 2'd3
  } state_t;

  localparam logic [PTR_W:0]   C_DEPTH   = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0]   C_CNT_ONE = 1;
  localparam logic [PTR_W-1:0] C_PTR_ONE = 1;
  localparam logic [CNT_W-1:0] C_STAT_ONE = 1;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [5:0]       r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W:0]   r_count;
  logic             r_push;
  logic [5:0]       r_data;
  logic [CNT_W-1:0] r_push_count;
  logic [CNT_W-1:0] r_drop_count;

  logic w_flush;
  logic w_wr_en;
  logic w_rd_en;
  logic w_drop;

  // Either logic-master override empties the skid FIFO and swallows any
  // same-cycle write.
  assign w_flush  = error_out | init;
  assign in_ready = ((r_state == S_FWD) || (r_state == S_PAUSE)) && (r_count < C_DEPTH);
  assign w_wr_en  = in_valid & in_ready & ~w_flush;
  assign w_rd_en  = (r_state == S_FWD) & ~Pausa_MF & ~w_flush & (r_count != '0);
  assign w_drop   = in_valid & ~in_ready;

  always_comb begin
    w_state_nxt = r_state;
    if (error_out) begin
      w_state_nxt = S_ERR;
    end else if (init) begin
      // Covers ERR as well: init is the only way out of ERR.
      w_state_nxt = S_WAIT;
    end else begin
      case (r_state)
        S_WAIT:  if (idle_out | active_out) w_state_nxt = S_FWD;
        S_FWD:   if (Pausa_MF)              w_state_nxt = S_PAUSE;
        S_PAUSE: if (!Pausa_MF)             w_state_nxt = S_FWD;
        default: w_state_nxt = S_ERR;   // ERR is sticky until init
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_state      <= S_WAIT;
      r_rd_ptr     <= '0;
      r_wr_ptr     <= '0;
      r_count      <= '0;
      r_push       <= 1'b0;
      r_data       <= '0;
      r_push_count <= '0;
      r_drop_count <= '0;
    end else begin
      r_state <= w_state_nxt;

      if (w_flush) begin
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
        r_count  <= '0;
        r_push   <= 1'b0;
      end else begin
        if (w_wr_en) r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
        if (w_rd_en) r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
        case ({w_wr_en, w_rd_en})
          2'b10:   r_count <= r_count + C_CNT_ONE;
          2'b01:   r_count <= r_count - C_CNT_ONE;
          default: r_count <= r_count;
        endcase
        r_push <= w_rd_en;
        // Data is held between pushes so the main FIFO sees a stable bus.
        if (w_rd_en) r_data <= r_mem[r_rd_ptr];
      end

      if (w_rd_en) r_push_count <= r_push_count + C_STAT_ONE;
      if (w_drop && (r_drop_count != '1)) r_drop_count <= r_drop_count + C_STAT_ONE;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_ptr] <= in_data;
  end

  assign push              = r_push;
  assign data_in_principal = r_data;
  assign state_o           = r_state;
  assign push_count        = r_push_count;
  assign drop_count        = r_drop_count;

endmodule
`default_nettype wire

// File: tb/tb_pcie_ingress_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_pcie_ingress_feeder
// Purpose  : Self-checking bench for pcie_ingress_feeder. A queue-based
//            reference model predicts every main-FIFO write; a monitor pops
//            the expected words whenever the DUT pushes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pcie_ingress_feeder;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset_L;
  logic       init, in_valid, Pausa_MF, active_out, idle_out, error_out;
  logic [5:0] in_data;
  logic       in_ready, push;
  logic [5:0] data_in_principal;
  logic [1:0] state_o;
  logic [7:0] push_count, drop_count;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int         m_state;          // 0 WAIT 1 FWD 2 PAUSE 3 ERR
  logic [5:0] skid[$];
  logic [5:0] exp_q[$];
  int         m_push_cnt, m_drop_cnt;
  bit         m_accepted;

  always #5 clk = ~clk;

  pcie_ingress_feeder #(.DEPTH(4), .PTR_W(2), .CNT_W(8)) dut (
    .clk(clk), .reset_L(reset_L), .init(init), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .Pausa_MF(Pausa_MF), .active_out(active_out), .idle_out(idle_out),
    .error_out(error_out), .push(push), .data_in_principal(data_in_principal),
    .state_o(state_o), .push_count(push_count), .drop_count(drop_count)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; skid.delete(); exp_q.delete();
    m_push_cnt = 0; m_drop_cnt = 0; m_accepted = 0;
  endtask

  // One clock edge of the specified behaviour, applied to the pre-edge inputs.
  task automatic model_edge();
    bit rdy, flush, rd;
    rdy   = (m_state == 1 || m_state == 2) && skid.size() < DEPTH;
    flush = error_out || init;
    rd    = m_state == 1 && !Pausa_MF && !flush && skid.size() > 0;
    m_accepted = 0;
    if (in_valid && !rdy && m_drop_cnt < 255) m_drop_cnt++;
    if (flush) skid.delete();
    else begin
      if (rd) begin
        exp_q.push_back(skid.pop_front());
        m_push_cnt = (m_push_cnt + 1) % 256;
      end
      if (in_valid && rdy) begin
        skid.push_back(in_data);
        m_accepted = 1;
      end
    end
    if (error_out) m_state = 3;
    else if (init) m_state = 0;
    else if (m_state == 0 && (idle_out || active_out)) m_state = 1;
    else if (m_state == 1 && Pausa_MF) m_state = 2;
    else if (m_state == 2 && !Pausa_MF) m_state = 1;
  endtask

  task automatic compare_status();
    check("state_o", state_o, m_state);
    check("in_ready", in_ready, ((m_state == 1 || m_state == 2) && skid.size() < DEPTH) ? 1 : 0);
    check("push_count", push_count, m_push_cnt);
    check("drop_count", drop_count, m_drop_cnt);
  endtask

  task automatic step(input logic i_init, input logic i_err, input logic i_idle, input logic i_act,
                      input logic i_pause, input logic i_vld, input logic [5:0] i_d);
    init = i_init; error_out = i_err; idle_out = i_idle; active_out = i_act;
    Pausa_MF = i_pause; in_valid = i_vld; in_data = i_d;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_status();
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 reset_L = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset_L = 1'b1;
  endtask

  // Monitor: every DUT push must match the oldest predicted word.
  always @(negedge clk) begin
    if (reset_L === 1'b1) begin
      logic [5:0] w;
      bit exp_push;
      exp_push = exp_q.size() != 0;
      check("push", push, exp_push ? 1 : 0);
      if (exp_push) begin
        w = exp_q.pop_front();
        if (push) check("data_in_principal", data_in_principal, w);
      end
    end
  end

  initial begin
    int k;
    reset_L = 1'b0; init = 0; in_valid = 0; in_data = 0; Pausa_MF = 0;
    active_out = 0; idle_out = 0; error_out = 0;
    model_reset();
    #1;
    check("reset push", push, 0);
    check("reset in_ready", in_ready, 0);
    check("reset state", state_o, 0);
    @(negedge clk); @(negedge clk);
    reset_L = 1'b1;

    // 1: enable, three back-to-back words
    step(0, 0, 1, 0, 0, 0, 6'h00);
    check("t1 state FWD", state_o, 1);
    step(0, 0, 0, 0, 0, 1, 6'h01);
    step(0, 0, 0, 0, 0, 1, 6'h02);
    step(0, 0, 0, 0, 0, 1, 6'h03);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 6'h00);
    check("t1 push_count", push_count, 3);

    // 2: eight paused cycles with a producer that holds data until accepted
    k = 0;
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 0, 0, 1, 1, 6'(8'h10 + k));
      if (m_accepted) k++;
    end
    check("t2 accepted", k, 4);
    check("t2 drop_count", drop_count, 4);
    check("t2 in_ready", in_ready, 0);
    check("t2 state PAUSE", state_o, 2);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0, 0, 6'h00);
    check("t2 state FWD", state_o, 1);
    check("t2 push_count", push_count, 7);

    // 3: error pulse with two words buffered
    step(0, 0, 0, 0, 1, 1, 6'h21);
    step(0, 0, 0, 0, 1, 1, 6'h22);
    step(0, 1, 0, 0, 1, 0, 6'h00);
    check("t3 state ERR", state_o, 3);
    check("t3 in_ready", in_ready, 0);
    step(0, 0, 1, 1, 0, 1, 6'h23);
    check("t3 sticky ERR", state_o, 3);
    step(1, 0, 0, 0, 0, 0, 6'h00);
    check("t3 state WAIT", state_o, 0);
    step(0, 0, 1, 0, 0, 0, 6'h00);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 6'h00);
    check("t3 no stale push", push_count, 7);

    // 4: continuous stream 0x00..0x3F
    for (int i = 0; i < 64; i++) step(0, 0, 0, 1, 0, 1, 6'(i));
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 6'h00);
    check("t4 push_count", push_count, (7 + 64) % 256);

    // 5: asynchronous reset between edges, mid-stream
    step(0, 0, 0, 0, 0, 1, 6'h2A);
    step(0, 0, 0, 0, 0, 1, 6'h2B);
    #2 reset_L = 1'b0;
    #1;
    check("t5 push", push, 0);
    check("t5 data", data_in_principal, 0);
    check("t5 push_count", push_count, 0);
    check("t5 drop_count", drop_count, 0);
    check("t5 state", state_o, 0);
    model_reset();
    @(negedge clk);
    reset_L = 1'b1;

    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom % 48) == 0, ($urandom % 96) == 0, ($urandom % 4) == 0, ($urandom % 4) == 0,
           ($urandom % 4) == 0, ($urandom % 4) != 0, 6'($urandom));
    end

    // 6: counter wrap and drop saturation
    do_reset();
    step(0, 0, 1, 0, 0, 0, 6'h00);
    for (int i = 0; i < 256; i++) step(0, 0, 0, 0, 0, 1, 6'(i));
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 6'h00);
    check("t6 push_count wrap", push_count, 0);
    for (int i = 0; i < 300; i++) step(1, 0, 0, 0, 0, 1, 6'h3F);
    check("t6 drop_count sat", drop_count, 255);
    check("t6 state WAIT", state_o, 0);

    check("scoreboard drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
